pwm_multichannel: RTL

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_multichannel_if.sv | 41 ++++
 rtl/pwm_debounce.sv | 92 +++++++++
 rtl/pwm_multichannel.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multichannel PWM generator.
//   MODE_EDGE / MODE_CENTER : values of i_mode and of the shadowed mode bit
//   dir_t                   : counting direction used in center-aligned mode
//   run_state_t             : run/stop state of the generator
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    typedef enum logic {
        RUN_STOPPED = 1'b0,
        RUN_ACTIVE  = 1'b1
    } run_state_t;

endpackage : pwm_pkg

// File: rtl/pwm_multichannel_if.sv
// -----------------------------------------------------------------------------
// pwm_multichannel_if
// Groups the control and output signals of the PWM generator.
//   i_boton, i_signal, i_mode, valor_pwm : driven by the controlling side
//   o_pwm, o_running, o_period_start     : driven by the generator
// Modports: master = controlling side, slave = generator side.
// -----------------------------------------------------------------------------
interface pwm_multichannel_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2
);

    logic                         i_boton;
    logic                         i_signal;
    logic                         i_mode;
    logic [CHANNELS*WIDTH-1:0]    valor_pwm;
    logic [CHANNELS-1:0]          o_pwm;
    logic                         o_running;
    logic                         o_period_start;

    modport master (
        output i_boton,
        output i_signal,
        output i_mode,
        output valor_pwm,
        input  o_pwm,
        input  o_running,
        input  o_period_start
    );

    modport slave (
        input  i_boton,
        input  i_signal,
        input  i_mode,
        input  valor_pwm,
        output o_pwm,
        output o_running,
        output o_period_start
    );

endinterface : pwm_multichannel_if

// File: rtl/pwm_debounce.sv
// -----------------------------------------------------------------------------
// pwm_debounce
// Two-flop synchronizer followed by a stability filter for a push-button.
//   clock   : system clock
//   reset   : asynchronous active-high reset
//   i_async : raw asynchronous button pin
//   o_rise  : one-cycle pulse when a new high level is accepted
// A level is accepted once the synchronized input has differed from the
// current accepted level for DEBOUNCE consecutive cycles. After reset the
// filter is disarmed: rising edges produce no pulse until the synchronized
// input has been seen low for DEBOUNCE consecutive cycles, so a button held
// through reset cannot start the generator.
// -----------------------------------------------------------------------------
module pwm_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    localparam int              CW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          rise_r;
    logic          armed_r;
    logic [CW-1:0] diff_cnt_r;
    logic [CW-1:0] arm_cnt_r;

    logic          diff_s;
    logic          accept_s;
    logic          arm_done_s;

    assign diff_s     = (sync2_r != level_r);
    assign accept_s   = diff_s && (diff_cnt_r == CNT_LAST);
    assign arm_done_s = (sync2_r == 1'b0) && (arm_cnt_r == CNT_LAST);
    assign o_rise     = rise_r;

    // Two-flop synchronizer for the raw pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= i_async;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter, accepted level and registered rising-edge pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_r    <= 1'b0;
            diff_cnt_r <= {CW{1'b0}};
            rise_r     <= 1'b0;
        end else if (accept_s) begin
            level_r    <= sync2_r;
            diff_cnt_r <= {CW{1'b0}};
            rise_r     <= sync2_r & armed_r;
        end else if (diff_s) begin
            diff_cnt_r <= diff_cnt_r + 1'b1;
            rise_r     <= 1'b0;
        end else begin
            // Input returned to the accepted level: the glitch is discarded.
            diff_cnt_r <= {CW{1'b0}};
            rise_r     <= 1'b0;
        end
    end

    // Arming: requires a stable low window after reset before edges count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_r   <= 1'b0;
            arm_cnt_r <= {CW{1'b0}};
        end else if (armed_r) begin
            armed_r   <= 1'b1;
            arm_cnt_r <= {CW{1'b0}};
        end else if (sync2_r) begin
            arm_cnt_r <= {CW{1'b0}};
        end else if (arm_done_s) begin
            armed_r   <= 1'b1;
            arm_cnt_r <= {CW{1'b0}};
        end else begin
            arm_cnt_r <= arm_cnt_r + 1'b1;
        end
    end

endmodule : pwm_debounce

// File: rtl/pwm_multichannel.sv
// -----------------------------------------------------------------------------
// pwm_multichannel
// Multichannel PWM generator with run/stop button, period-sync input and
// edge- or center-aligned counting.
//   clock          : system clock, all state on the rising edge
//   reset          : asynchronous active-high reset
//   i_boton        : asynchronous run/stop push-button (debounced)
//   i_signal       : asynchronous period-sync input (rising edge restarts)
//   i_mode         : MODE_EDGE (0) or MODE_CENTER (1), sampled per period
//   valor_pwm      : packed duties, channel k at [k*WIDTH +: WIDTH]
//   o_pwm          : registered PWM outputs
//   o_running      : high while the generator runs
//   o_period_start : one-cycle pulse in the first cycle of every period
// Mode and duties are shadowed at each period start so mid-period changes
// only take effect at the following period. All outputs come from flops;
// o_pwm is computed from the next counter/shadow values so it lines up with
// the counter value of the same cycle.
// -----------------------------------------------------------------------------
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_boton,
    input  logic                      i_signal,
    input  logic                      i_mode,
    input  logic [CHANNELS*WIDTH-1:0] valor_pwm,
    output logic [CHANNELS-1:0]       o_pwm,
    output logic                      o_running,
    output logic                      o_period_start
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_LAST = CNT_MAX - 1'b1;

    run_state_t                state_r;
    run_state_t                state_nx_s;
    dir_t                      dir_r;
    dir_t                      dir_nx_s;
    logic [WIDTH-1:0]          cnt_r;
    logic [WIDTH-1:0]          cnt_nx_s;
    logic                      mode_sh_r;
    logic                      mode_nx_s;
    logic [CHANNELS*WIDTH-1:0] duty_sh_r;
    logic [CHANNELS*WIDTH-1:0] duty_nx_s;
    logic [CHANNELS-1:0]       pwm_r;
    logic [CHANNELS-1:0]       pwm_nx_s;
    logic                      ps_r;
    logic                      start_nx_s;
    logic                      reload_s;

    logic                      sig1_r;
    logic                      sig2_r;
    logic                      sig3_r;
    logic                      sig_rise_s;
    logic                      btn_rise_s;
    logic                      wrap_s;

    pwm_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btn_debounce (
        .clock   (clock),
        .reset   (reset),
        .i_async (i_boton),
        .o_rise  (btn_rise_s)
    );

    // Two-flop synchronizer for i_signal plus one delay flop for edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig1_r <= 1'b0;
            sig2_r <= 1'b0;
            sig3_r <= 1'b0;
        end else begin
            sig1_r <= i_signal;
            sig2_r <= sig1_r;
            sig3_r <= sig2_r;
        end
    end

    assign sig_rise_s = sig2_r & ~sig3_r;

    // Natural end of the current period under the shadowed mode.
    always_comb begin
        wrap_s = 1'b0;
        if (mode_sh_r == MODE_CENTER) begin
            wrap_s = (dir_r == DIR_DOWN) && (cnt_r == CNT_ZERO);
        end else begin
            wrap_s = (cnt_r == CNT_LAST);
        end
    end

    // Run state, counter and direction next-state logic.
    // A button toggle outranks a restart; a sync edge landing on a natural
    // wrap is the same restart, so only one period start is produced.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        dir_nx_s   = dir_r;
        start_nx_s = 1'b0;
        reload_s   = 1'b0;
        case (state_r)
            RUN_STOPPED: begin
                cnt_nx_s = CNT_ZERO;
                dir_nx_s = DIR_UP;
                if (btn_rise_s) begin
                    state_nx_s = RUN_ACTIVE;
                    start_nx_s = 1'b1;
                    reload_s   = 1'b1;
                end else begin
                    state_nx_s = RUN_STOPPED;
                end
            end
            RUN_ACTIVE: begin
                if (btn_rise_s) begin
                    state_nx_s = RUN_STOPPED;
                    cnt_nx_s   = CNT_ZERO;
                    dir_nx_s   = DIR_UP;
                end else if (sig_rise_s || wrap_s) begin
                    cnt_nx_s   = CNT_ZERO;
                    dir_nx_s   = DIR_UP;
                    start_nx_s = 1'b1;
                    reload_s   = 1'b1;
                end else if (mode_sh_r == MODE_EDGE) begin
                    cnt_nx_s = cnt_r + 1'b1;
                end else if (dir_r == DIR_UP) begin
                    // Turning point: MAX-1 is held for a second cycle.
                    if (cnt_r == CNT_LAST) begin
                        dir_nx_s = DIR_DOWN;
                    end else begin
                        cnt_nx_s = cnt_r + 1'b1;
                    end
                end else begin
                    cnt_nx_s = cnt_r - 1'b1;
                end
            end
            default: begin
                state_nx_s = RUN_STOPPED;
                cnt_nx_s   = CNT_ZERO;
                dir_nx_s   = DIR_UP;
            end
        endcase
    end

    // Shadow registers take new duty/mode only at a period start.
    always_comb begin
        mode_nx_s = mode_sh_r;
        duty_nx_s = duty_sh_r;
        if (reload_s) begin
            mode_nx_s = i_mode;
            duty_nx_s = valor_pwm;
        end else begin
            mode_nx_s = mode_sh_r;
            duty_nx_s = duty_sh_r;
        end
    end

    // Per-channel compare against the counter value of the coming cycle.
    always_comb begin
        pwm_nx_s = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            if (state_nx_s == RUN_ACTIVE) begin
                pwm_nx_s[k] = (cnt_nx_s < duty_nx_s[k*WIDTH +: WIDTH]);
            end else begin
                pwm_nx_s[k] = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= RUN_STOPPED;
            cnt_r     <= CNT_ZERO;
            dir_r     <= DIR_UP;
            mode_sh_r <= MODE_EDGE;
            duty_sh_r <= {(CHANNELS*WIDTH){1'b0}};
            pwm_r     <= {CHANNELS{1'b0}};
            ps_r      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            dir_r     <= dir_nx_s;
            mode_sh_r <= mode_nx_s;
            duty_sh_r <= duty_nx_s;
            pwm_r     <= pwm_nx_s;
            ps_r      <= start_nx_s;
        end
    end

    assign o_pwm          = pwm_r;
    assign o_running      = (state_r == RUN_ACTIVE);
    assign o_period_start = ps_r;

endmodule : pwm_multichannel
